ha_array_accum_seq: RTL and testbench



---
 rtl/ha_seq_pkg.sv | 27 ++
 rtl/ha_pair_shift.sv | 20 ++
 rtl/ha_array_accum_seq.sv | 117 +++++++++++
 tb/tb_ha_array_accum_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ha_seq_pkg.sv
// Shared types, sizes and pair arithmetic for the half-adder-array accumulator.
package ha_seq_pkg;

  localparam int NPAIR  = 4;
  localparam int T_W    = 9;
  localparam int B_W    = 7;
  localparam int V_W    = 10;
  localparam int PROD_W = 16;
  localparam int ACC_W  = 17;
  localparam int CNT_W  = $clog2(NPAIR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [NPAIR-1:0][T_W-1:0] t_vec_t;
  typedef logic [NPAIR-1:0][B_W-1:0] b_vec_t;

  // Value of one row pair: the top row plus the bottom row weighted by 4.
  function automatic logic [V_W-1:0] pair_value(input logic [T_W-1:0] t,
                                                input logic [B_W-1:0] b);
    return V_W'(t) + V_W'({b, 2'b00});
  endfunction

endpackage

// File: rtl/ha_pair_shift.sv
// Selects the row pair addressed by cnt and aligns it to weight 4^cnt.
module ha_pair_shift
  import ha_seq_pkg::*;
(
  input  logic [CNT_W-1:0] cnt_i,
  input  t_vec_t           t_vec_i,
  input  b_vec_t           b_vec_i,
  output logic [ACC_W-1:0] addend_o
);

  logic [V_W-1:0] pair_v;

  // Form the selected pair value and shift it by two bits per pair index.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pair_v   = pair_value(t_vec_i[cnt_i], b_vec_i[cnt_i]);
    addend_o = ACC_W'(pair_v) << {cnt_i, 1'b0};
  end

endmodule

// File: rtl/ha_array_accum_seq.sv
// Captures four row-pair vectors and folds them into a saturated 16-bit
// product with one shared adder, one pair per cycle.
module ha_array_accum_seq
  import ha_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [T_W-1:0]    t0_i,
  input  logic [T_W-1:0]    t1_i,
  input  logic [T_W-1:0]    t2_i,
  input  logic [T_W-1:0]    t3_i,
  input  logic [B_W-1:0]    b0_i,
  input  logic [B_W-1:0]    b1_i,
  input  logic [B_W-1:0]    b2_i,
  input  logic [B_W-1:0]    b3_i,
  input  logic [NPAIR-1:0]  pair_en_i,
  input  logic              abort_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PROD_W-1:0] product_o,
  output logic              sat_o
);

  state_e              state_q;
  t_vec_t              t_q;
  b_vec_t              b_q;
  logic [NPAIR-1:0]    en_q;
  logic [ACC_W-1:0]    acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [PROD_W-1:0]   product_q;
  logic                sat_q;

  logic [ACC_W-1:0]    addend;
  logic [ACC_W-1:0]    acc_d;

  ha_pair_shift u_pair_shift (
    .cnt_i    (cnt_q),
    .t_vec_i  (t_q),
    .b_vec_i  (b_q),
    .addend_o (addend)
  );

  // Shared adder: masked pairs contribute zero but still take their cycle.
  always_comb begin
    acc_d = acc_q + (en_q[cnt_q] ? addend : '0);
  end

  // Control FSM with registered handshake and result outputs; abort wins over everything.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  // NOTE: the captured operand registers are few and small, so they are reset along with the control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      t_q         <= '0;
      b_q         <= '0;
      en_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      sat_q       <= 1'b0;
    end else if (abort_i) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            t_q        <= {t3_i, t2_i, t1_i, t0_i};
            b_q        <= {b3_i, b2_i, b1_i, b0_i};
            en_q       <= pair_en_i;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ACC;
          end
        end
        ACC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NPAIR - 1)) begin
            product_q   <= acc_d[ACC_W-1] ? {PROD_W{1'b1}} : acc_d[PROD_W-1:0];
            sat_q       <= acc_d[ACC_W-1];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign product_o   = product_q;
  assign sat_o       = sat_q;

endmodule

// File: tb/tb_ha_array_accum_seq.sv
// Directed bench for ha_array_accum_seq: latency, arithmetic, masking,
// saturation, backpressure, abort, asynchronous reset and throughput.
module tb_ha_array_accum_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [8:0]  t0, t1, t2, t3;
  logic [6:0]  b0, b1, b2, b3;
  logic [3:0]  pair_en;
  logic        abort;
  logic        out_valid, out_ready;
  logic [15:0] product;
  logic        sat;

  int checks   = 0;
  int failures = 0;

  localparam logic [35:0] ALL_T = {4{9'h1FF}};
  localparam logic [27:0] ALL_B = {4{7'h7F}};

  always #5 clk = ~clk;

  ha_array_accum_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .t0_i        (t0),
    .t1_i        (t1),
    .t2_i        (t2),
    .t3_i        (t3),
    .b0_i        (b0),
    .b1_i        (b1),
    .b2_i        (b2),
    .b3_i        (b3),
    .pair_en_i   (pair_en),
    .abort_i     (abort),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .product_o   (product),
    .sat_o       (sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [35:0] tv, input logic [27:0] bv, input logic [3:0] en);
    t0 = tv[8:0];   t1 = tv[17:9];  t2 = tv[26:18]; t3 = tv[35:27];
    b0 = bv[6:0];   b1 = bv[13:7];  b2 = bv[20:14]; b3 = bv[27:21];
    pair_en = en;
  endtask

  // Present one transaction for a single edge; reports whether it was ready.
  task automatic accept_op(input logic [35:0] tv, input logic [27:0] bv,
                           input logic [3:0] en, output bit ok);
    set_vec(tv, bv, en);
    in_valid = 1'b1;
    ok = in_ready;
    tick();
    in_valid = 1'b0;
    set_vec('0, '0, 4'h0);
  endtask

  // Counts edges after the accept edge until out_valid; -1 if the bound expires.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [35:0] tv, input logic [27:0] bv,
                        input logic [3:0] en, input logic [15:0] exp_p, input logic exp_s);
    bit ok;
    int lat;
    accept_op(tv, bv, en, ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL %s_accept: in_ready=%0b expected 1", name, ok);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL %s_latency: edges=%0d expected 4", name, lat);
    end
    checks++;
    if (product !== exp_p) begin
      failures++;
      $display("FAIL %s_product: got %0d expected %0d", name, product, exp_p);
    end
    checks++;
    if (sat !== exp_s) begin
      failures++;
      $display("FAIL %s_sat: got %0b expected %0b", name, sat, exp_s);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_handshake: out_valid=%0b in_ready=%0b expected 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0 || sat !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: in_ready=%0b out_valid=%0b product=%0d sat=%0b expected 1/0/0/0",
               in_ready, out_valid, product, sat);
    end
  endtask

  task automatic test_arith();
    run_op("t0_only",   36'h0FF,            28'h0,            4'hF, 16'd255,   1'b0);
    run_op("t3_b3",     {9'h1FF, 27'h0},    {7'h7F, 21'h0},   4'hF, 16'd65216, 1'b0);
    run_op("saturate",  ALL_T,              ALL_B,            4'hF, 16'hFFFF,  1'b1);
    run_op("masked",    ALL_T,              ALL_B,            4'h7, 16'd21399, 1'b0);
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    accept_op(ALL_T, ALL_B, 4'hF, ok);
    wait_valid(lat);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL bp_latency: edges=%0d expected 4", lat);
    end
    for (int i = 0; i < 10; i++) begin
      set_vec(36'h001, 28'h0, 4'hF);
      in_valid = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 16'hFFFF || sat !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold_%0d: out_valid=%0b in_ready=%0b product=%0d sat=%0b expected 1/0/65535/1",
                 i, out_valid, in_ready, product, sat);
      end
    end
    in_valid = 1'b0;
    set_vec('0, '0, 4'h0);
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready_in_handshake: in_ready=%0b expected 0", in_ready);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_after_handshake: in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid);
    end
    run_op("bp_next", 36'h200, 28'h0, 4'hF, 16'd4, 1'b0);
  endtask

  task automatic test_abort();
    bit ok;
    bit seen;
    accept_op(ALL_T, ALL_B, 4'hF, ok);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_acc: in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_result: out_valid seen=%0b expected 0", seen);
    end
    run_op("abort_next", 36'h200, 28'h0, 4'hF, 16'd4, 1'b0);

    // Abort coinciding with an accept captures nothing.
    set_vec(ALL_T, ALL_B, 4'hF);
    in_valid = 1'b1;
    abort = 1'b1;
    tick();
    in_valid = 1'b0;
    abort = 1'b0;
    set_vec('0, '0, 4'h0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid || !in_ready) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_with_accept: busy/valid seen=%0b expected 0", seen);
    end

    // Abort coinciding with the result handshake drops the result too.
    accept_op(36'h0FF, 28'h0, 4'hF, ok);
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b1;
    abort = 1'b1;
    tick();
    out_ready = 1'b0;
    abort = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_done: in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    accept_op(ALL_T, ALL_B, 4'hF, ok);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0 || sat !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_acc: in_ready=%0b out_valid=%0b product=%0d sat=%0b expected 1/0/0/0",
               in_ready, out_valid, product, sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = out_valid;
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_result: out_valid=%0b expected 0", seen);
    end
    run_op("reset_next", 36'h200, 28'h0, 4'hF, 16'd4, 1'b0);
  endtask

  task automatic test_back_to_back();
    int acc_cyc[4];
    int n = 0;
    out_ready = 1'b1;
    set_vec(36'h0FF, 28'h0, 4'hF);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (in_ready && n < 4) begin
        acc_cyc[n] = cyc;
        n++;
      end
      if (out_valid) begin
        checks++;
        if (product !== 16'd255) begin
          failures++;
          $display("FAIL b2b_product_c%0d: got %0d expected 255", cyc, product);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_vec('0, '0, 4'h0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (n < 3 || acc_cyc[1] - acc_cyc[0] != 6 || acc_cyc[2] - acc_cyc[1] != 6) begin
      failures++;
      $display("FAIL b2b_interval: accepts=%0d first gaps=%0d,%0d expected 6,6",
               n, acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    abort     = 1'b0;
    set_vec('0, '0, 4'h0);
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_arith();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
